// File: rtl/cci_mpf_shim_wr_packet_heap.sv
// AFU-edge write-data path: gathers multi-beat write packets into heap slots,
// recycles slots through a two-write-port free-index FIFO and emits one control flit per packet.
module cci_mpf_shim_wr_packet_heap #(
    parameter int N_SLOTS           = 32,
    parameter int MAX_BEATS         = 4,
    parameter int ADDR_WIDTH        = 42,
    parameter int DATA_WIDTH        = 512,
    parameter int ALMFULL_THRESHOLD = 8,
    localparam int SLOT_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1,
    localparam int LEN_W  = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_valid,
    input  logic                    in_sop,
    input  logic [LEN_W-1:0]        in_len,
    input  logic [ADDR_WIDTH-1:0]   in_addr,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic                    in_almfull,
    output logic                    heap_wen,
    output logic [SLOT_W+LEN_W-1:0] heap_widx,
    output logic [DATA_WIDTH-1:0]   heap_wdata,
    output logic                    out_valid,
    output logic [ADDR_WIDTH-1:0]   out_addr,
    output logic [LEN_W-1:0]        out_len,
    output logic [SLOT_W-1:0]       out_slot,
    input  logic                    dn_almfull,
    input  logic                    free_en,
    input  logic [SLOT_W-1:0]       free_slot,
    output logic [3:0]              err
);

    localparam int CNT_W = $clog2(N_SLOTS + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DROP   = 2'd2
    } pkt_state_e;

    pkt_state_e              state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic [SLOT_W-1:0]       slot_q, slot_d;
    logic [LEN_W-1:0]        cnt_q, cnt_d;

    logic [SLOT_W-1:0]       fifo_q [N_SLOTS];
    logic [SLOT_W-1:0]       head_q, head_d;
    logic [SLOT_W-1:0]       tail_q, tail_d;
    logic [CNT_W-1:0]        count_q, count_d;

    logic                    almf_q, almf_d;
    logic [3:0]              err_q, err_d;
    logic                    wen_q, wen_d;
    logic [SLOT_W+LEN_W-1:0] widx_q, widx_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    ov_q, ov_d;
    logic [ADDR_WIDTH-1:0]   oaddr_q, oaddr_d;
    logic [LEN_W-1:0]        olen_q, olen_d;
    logic [SLOT_W-1:0]       oslot_q, oslot_d;

    logic                    abandon;
    logic                    eop_pop;
    logic                    free_ok;
    logic [1:0]              pop_n;
    logic [1:0]              push_n;
    logic [LEN_W-1:0]        len_in;
    logic [LEN_W-1:0]        cnt_inc;
    logic [SLOT_W-1:0]       new_slot;
    logic [CNT_W-1:0]        occ_after;
    logic                    wr0_en, wr1_en;
    logic [SLOT_W-1:0]       wr0_idx, wr1_idx;
    logic                    raw_almfull;

    // With one beat per packet every sop is its own eop, whatever in_len says.
    assign len_in  = (MAX_BEATS == 1) ? '0 : in_len;
    assign cnt_inc = cnt_q + LEN_W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            slot_q  <= '0;
            cnt_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= CNT_W'(N_SLOTS);
            almf_q  <= 1'b1;
            err_q   <= '0;
            wen_q   <= 1'b0;
            widx_q  <= '0;
            wdata_q <= '0;
            ov_q    <= 1'b0;
            oaddr_q <= '0;
            olen_q  <= '0;
            oslot_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            slot_q  <= slot_d;
            cnt_q   <= cnt_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            almf_q  <= almf_d;
            err_q   <= err_d;
            wen_q   <= wen_d;
            widx_q  <= widx_d;
            wdata_q <= wdata_d;
            ov_q    <= ov_d;
            oaddr_q <= oaddr_d;
            olen_q  <= olen_d;
            oslot_q <= oslot_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_SLOTS; i++) begin
                fifo_q[i] <= SLOT_W'(i);
            end
        end else begin
            if (wr0_en) fifo_q[wr0_idx] <= slot_q;
            if (wr1_en) fifo_q[wr1_idx] <= free_slot;
        end
    end

    // An abandoned packet's slot is still at the head: it is popped and
    // re-pushed at the tail, so the new sop allocates from one entry further on.
    always_comb begin
        new_slot = fifo_q[head_q + SLOT_W'(abandon)];
        if (abandon && count_q == CNT_W'(1)) begin
            new_slot = slot_q;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        slot_d  = slot_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        wen_d   = 1'b0;
        widx_d  = widx_q;
        wdata_d = wdata_q;
        ov_d    = 1'b0;
        oaddr_d = oaddr_q;
        olen_d  = olen_q;
        oslot_d = oslot_q;
        abandon = 1'b0;
        eop_pop = 1'b0;

        if (in_valid && in_sop) begin
            if (state_q == ST_ACTIVE) begin
                abandon  = 1'b1;
                err_d[0] = 1'b1;
            end
            if ((in_addr[LEN_W-1:0] & len_in) != '0) begin
                err_d[1] = 1'b1;
            end
            if (count_q == '0) begin
                err_d[2] = 1'b1;
                state_d  = ST_DROP;
            end else begin
                addr_d  = in_addr;
                len_d   = len_in;
                slot_d  = new_slot;
                cnt_d   = '0;
                wen_d   = 1'b1;
                widx_d  = {new_slot, LEN_W'(0)};
                wdata_d = in_data;
                if (len_in == '0) begin
                    eop_pop = 1'b1;
                    ov_d    = 1'b1;
                    oaddr_d = in_addr;
                    olen_d  = len_in;
                    oslot_d = new_slot;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ACTIVE;
                end
            end
        end else if (in_valid) begin
            case (state_q)
                ST_ACTIVE: begin
                    cnt_d   = cnt_inc;
                    wen_d   = 1'b1;
                    widx_d  = {slot_q, cnt_inc};
                    wdata_d = in_data;
                    if (cnt_inc == len_q) begin
                        eop_pop = 1'b1;
                        ov_d    = 1'b1;
                        oaddr_d = addr_q;
                        olen_d  = len_q;
                        oslot_d = slot_q;
                        state_d = ST_IDLE;
                    end
                end
                ST_IDLE: err_d[0] = 1'b1;
                default: ;
            endcase
        end

        // A slot popped this cycle makes room for a returning one.
        occ_after = count_q - CNT_W'(eop_pop);
        free_ok   = free_en && (occ_after != CNT_W'(N_SLOTS));
        if (free_en && !free_ok) begin
            err_d[3] = 1'b1;
        end

        pop_n   = {1'b0, abandon} + {1'b0, eop_pop};
        push_n  = {1'b0, abandon} + {1'b0, free_ok};
        wr0_en  = abandon;
        wr0_idx = tail_q;
        wr1_en  = free_ok;
        wr1_idx = tail_q + SLOT_W'(abandon);
        head_d  = head_q + SLOT_W'(pop_n);
        tail_d  = tail_q + SLOT_W'(push_n);
        count_d = count_q - CNT_W'(pop_n) + CNT_W'(push_n);
    end

    // Almost-full may only rise between packets; once up it holds while the cause persists.
    assign raw_almfull = dn_almfull || (int'(count_q) < ALMFULL_THRESHOLD + 2);
    assign almf_d      = raw_almfull && (almf_q || (state_d != ST_ACTIVE));

    assign in_almfull = almf_q;
    assign heap_wen   = wen_q;
    assign heap_widx  = widx_q;
    assign heap_wdata = wdata_q;
    assign out_valid  = ov_q;
    assign out_addr   = oaddr_q;
    assign out_len    = olen_q;
    assign out_slot   = oslot_q;
    assign err        = err_q;

endmodule

// File: tb/tb_cci_mpf_shim_wr_packet_heap.sv
// Directed bench for the write packet heap: vector table for the basic paths,
// hand-written sequences for almost-full, slot recycling, abandon and async reset.
module tb_cci_mpf_shim_wr_packet_heap;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_sop = 1'b0;
    logic [1:0]   in_len = '0;
    logic [41:0]  in_addr = '0;
    logic [511:0] in_data = '0;
    logic         in_almfull;
    logic         heap_wen;
    logic [6:0]   heap_widx;
    logic [511:0] heap_wdata;
    logic         out_valid;
    logic [41:0]  out_addr;
    logic [1:0]   out_len;
    logic [4:0]   out_slot;
    logic         dn_almfull = 1'b0;
    logic         free_en = 1'b0;
    logic [4:0]   free_slot = '0;
    logic [3:0]   err;

    int checks = 0;
    int errors = 0;

    cci_mpf_shim_wr_packet_heap dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_sop(in_sop), .in_len(in_len), .in_addr(in_addr), .in_data(in_data),
        .in_almfull(in_almfull),
        .heap_wen(heap_wen), .heap_widx(heap_widx), .heap_wdata(heap_wdata),
        .out_valid(out_valid), .out_addr(out_addr), .out_len(out_len), .out_slot(out_slot),
        .dn_almfull(dn_almfull), .free_en(free_en), .free_slot(free_slot), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (act timeout, exp finish)");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        v;
        logic        sop;
        logic [1:0]  len;
        logic [41:0] addr;
        logic        dn;
        logic        e_wen;
        logic [6:0]  e_widx;
        logic        e_ov;
        logic [41:0] e_oaddr;
        logic [1:0]  e_olen;
        logic [4:0]  e_oslot;
        logic        e_alm;
        logic [3:0]  e_err;
    } vec_t;

    vec_t vt[15];

    function automatic vec_t mk(logic v, logic sop, logic [1:0] len, logic [41:0] addr, logic dn,
                                logic e_wen, logic [6:0] e_widx, logic e_ov, logic [41:0] e_oaddr,
                                logic [1:0] e_olen, logic [4:0] e_oslot, logic e_alm, logic [3:0] e_err);
        vec_t r;
        r.v = v; r.sop = sop; r.len = len; r.addr = addr; r.dn = dn;
        r.e_wen = e_wen; r.e_widx = e_widx; r.e_ov = e_ov; r.e_oaddr = e_oaddr;
        r.e_olen = e_olen; r.e_oslot = e_oslot; r.e_alm = e_alm; r.e_err = e_err;
        return r;
    endfunction

    function automatic logic [511:0] mk_data(int i);
        return {16{32'hA5A50000 + 32'(i)}};
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic v, logic sop, logic [1:0] len, logic [41:0] addr,
                         logic fen, logic [4:0] fslot, logic [511:0] data);
        @(negedge clk);
        in_valid  = v;
        in_sop    = sop;
        in_len    = len;
        in_addr   = addr;
        free_en   = fen;
        free_slot = fslot;
        in_data   = data;
        step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n    = 1'b0;
        in_valid   = 1'b0;
        in_sop     = 1'b0;
        free_en    = 1'b0;
        dn_almfull = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        // Basic write, misalignment, idle beat and dn_almfull hold-off.
        vt[0]  = mk(0, 0, 0, 42'h000, 0, 0, 7'd0,  0, 42'h0,   0, 0, 0, 4'h0);
        vt[1]  = mk(1, 1, 3, 42'h100, 0, 1, 7'd0,  0, 42'h0,   0, 0, 0, 4'h0);
        vt[2]  = mk(1, 0, 0, 42'h000, 0, 1, 7'd1,  0, 42'h0,   0, 0, 0, 4'h0);
        vt[3]  = mk(1, 0, 0, 42'h000, 0, 1, 7'd2,  0, 42'h0,   0, 0, 0, 4'h0);
        vt[4]  = mk(1, 0, 0, 42'h000, 0, 1, 7'd3,  1, 42'h100, 3, 0, 0, 4'h0);
        vt[5]  = mk(0, 0, 0, 42'h000, 0, 0, 7'd0,  0, 42'h0,   0, 0, 0, 4'h0);
        vt[6]  = mk(1, 1, 1, 42'h101, 0, 1, 7'd4,  0, 42'h0,   0, 0, 0, 4'h2);
        vt[7]  = mk(1, 0, 0, 42'h000, 0, 1, 7'd5,  1, 42'h101, 1, 1, 0, 4'h2);
        vt[8]  = mk(1, 0, 0, 42'h000, 0, 0, 7'd0,  0, 42'h0,   0, 0, 0, 4'h3);
        vt[9]  = mk(1, 1, 3, 42'h200, 0, 1, 7'd8,  0, 42'h0,   0, 0, 0, 4'h3);
        vt[10] = mk(1, 0, 0, 42'h000, 1, 1, 7'd9,  0, 42'h0,   0, 0, 0, 4'h3);
        vt[11] = mk(1, 0, 0, 42'h000, 1, 1, 7'd10, 0, 42'h0,   0, 0, 0, 4'h3);
        vt[12] = mk(1, 0, 0, 42'h000, 1, 1, 7'd11, 1, 42'h200, 3, 2, 1, 4'h3);
        vt[13] = mk(0, 0, 0, 42'h000, 1, 0, 7'd0,  0, 42'h0,   0, 0, 1, 4'h3);
        vt[14] = mk(0, 0, 0, 42'h000, 0, 0, 7'd0,  0, 42'h0,   0, 0, 0, 4'h3);

        // Values held during reset.
        repeat (2) @(negedge clk);
        chk("rst_almfull", 64'(in_almfull), 64'd1);
        chk("rst_wen", 64'(heap_wen), 64'd0);
        chk("rst_ov", 64'(out_valid), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_widx", 64'(heap_widx), 64'd0);
        chk("rst_oaddr", 64'(out_addr), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            dn_almfull = vt[i].dn;
            in_valid   = vt[i].v;
            in_sop     = vt[i].sop;
            in_len     = vt[i].len;
            in_addr    = vt[i].addr;
            in_data    = mk_data(i);
            step();
            chk($sformatf("v%0d_wen", i), 64'(heap_wen), 64'(vt[i].e_wen));
            if (vt[i].e_wen) begin
                chk($sformatf("v%0d_widx", i), 64'(heap_widx), 64'(vt[i].e_widx));
                checks++;
                if (heap_wdata !== mk_data(i)) begin
                    errors++;
                    $display("FAIL v%0d_wdata: got 0x%0h expected 0x%0h", i, heap_wdata[31:0], mk_data(i) & 512'hFFFFFFFF);
                end
            end
            chk($sformatf("v%0d_ov", i), 64'(out_valid), 64'(vt[i].e_ov));
            if (vt[i].e_ov) begin
                chk($sformatf("v%0d_oaddr", i), 64'(out_addr), 64'(vt[i].e_oaddr));
                chk($sformatf("v%0d_olen", i), 64'(out_len), 64'(vt[i].e_olen));
                chk($sformatf("v%0d_oslot", i), 64'(out_slot), 64'(vt[i].e_oslot));
            end
            chk($sformatf("v%0d_alm", i), 64'(in_almfull), 64'(vt[i].e_alm));
            chk($sformatf("v%0d_err", i), 64'(err), 64'(vt[i].e_err));
        end
        drive(0, 0, 0, 0, 0, 0, '0);

        // Exhaust all slots with single-beat packets; almost-full follows the free count.
        do_reset();
        for (int k = 1; k <= 32; k++) begin
            drive(1, 1, 0, 42'(k * 4), 0, 0, mk_data(k));
            chk($sformatf("fill%0d_ov", k), 64'(out_valid), 64'd1);
            chk($sformatf("fill%0d_slot", k), 64'(out_slot), 64'(k - 1));
            chk($sformatf("fill%0d_alm", k), 64'(in_almfull), 64'(k >= 24));
        end
        drive(1, 1, 0, 42'h400, 0, 0, '0);
        chk("nofree_err", 64'(err), 64'h4);
        chk("nofree_wen", 64'(heap_wen), 64'd0);
        chk("nofree_ov", 64'(out_valid), 64'd0);
        drive(1, 0, 0, 0, 0, 0, '0);
        chk("drop_beat_err", 64'(err), 64'h4);
        chk("drop_beat_wen", 64'(heap_wen), 64'd0);
        drive(0, 0, 0, 0, 0, 0, '0);

        // Free while popping a full FIFO: slot 5 comes back after 31 more allocations.
        do_reset();
        drive(1, 1, 0, 42'h0, 1, 5'd5, '0);
        chk("popfree_slot", 64'(out_slot), 64'd0);
        chk("popfree_err", 64'(err), 64'd0);
        for (int k = 1; k <= 31; k++) begin
            drive(1, 1, 0, 42'h0, 0, 0, '0);
            chk($sformatf("realloc%0d_slot", k), 64'(out_slot), 64'(k));
        end
        drive(1, 1, 0, 42'h0, 0, 0, '0);
        chk("realloc_slot5", 64'(out_slot), 64'd5);
        chk("realloc_err", 64'(err), 64'd0);
        drive(0, 0, 0, 0, 0, 0, '0);

        // Free into a full FIFO is rejected.
        do_reset();
        drive(0, 0, 0, 0, 1, 5'd3, '0);
        chk("free_full_err", 64'(err), 64'h8);
        drive(0, 0, 0, 0, 0, 0, '0);

        // Sop mid-packet with a simultaneous free: abandon lands first, then the free.
        do_reset();
        drive(1, 1, 0, 42'h0, 0, 0, '0);
        chk("ab_pre_slot", 64'(out_slot), 64'd0);
        drive(1, 1, 3, 42'h300, 0, 0, '0);
        chk("ab_b0_widx", 64'(heap_widx), 64'd4);
        drive(1, 0, 0, 0, 0, 0, '0);
        chk("ab_b1_widx", 64'(heap_widx), 64'd5);
        drive(1, 1, 0, 42'h400, 1, 5'd0, '0);
        chk("ab_new_widx", 64'(heap_widx), 64'd8);
        chk("ab_new_ov", 64'(out_valid), 64'd1);
        chk("ab_new_oaddr", 64'(out_addr), 64'h400);
        chk("ab_new_slot", 64'(out_slot), 64'd2);
        chk("ab_err", 64'(err), 64'h1);
        for (int k = 3; k <= 31; k++) begin
            drive(1, 1, 0, 42'h0, 0, 0, '0);
        end
        chk("ab_tail_last", 64'(out_slot), 64'd31);
        drive(1, 1, 0, 42'h0, 0, 0, '0);
        chk("ab_ret_slot1", 64'(out_slot), 64'd1);
        drive(1, 1, 0, 42'h0, 0, 0, '0);
        chk("ab_ret_slot0", 64'(out_slot), 64'd0);
        drive(0, 0, 0, 0, 0, 0, '0);

        // Async reset in the middle of a 4-beat packet.
        do_reset();
        drive(1, 1, 3, 42'h500, 0, 0, '0);
        drive(1, 0, 0, 0, 0, 0, '0);
        drive(1, 0, 0, 0, 0, 0, '0);
        chk("ar_b2_widx", 64'(heap_widx), 64'd2);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_alm", 64'(in_almfull), 64'd1);
        chk("ar_err", 64'(err), 64'd0);
        chk("ar_wen", 64'(heap_wen), 64'd0);
        chk("ar_ov", 64'(out_valid), 64'd0);
        drive(1, 0, 0, 0, 0, 0, '0);
        chk("ar_hold_ov", 64'(out_valid), 64'd0);
        chk("ar_hold_alm", 64'(in_almfull), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        reset_n  = 1'b1;
        step();
        chk("ar_rel_ov", 64'(out_valid), 64'd0);
        chk("ar_rel_alm", 64'(in_almfull), 64'd0);
        drive(1, 1, 0, 42'h600, 0, 0, '0);
        chk("ar_new_slot", 64'(out_slot), 64'd0);
        chk("ar_new_ov", 64'(out_valid), 64'd1);
        drive(1, 0, 0, 0, 0, 0, '0);
        chk("ar_idle_err", 64'(err), 64'h1);
        chk("ar_idle_wen", 64'(heap_wen), 64'd0);
        chk("ar_idle_ov", 64'(out_valid), 64'd0);
        drive(0, 0, 0, 0, 0, 0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
